// File: rtl/ttt_board.sv
// N x N game board: accepts moves over valid/ready, rejects illegal ones, rotates turns and
// declares a draw or winner. Line (win) detection is built only when TTT_WIN_DETECT_EN is defined.
module ttt_board #(
    parameter int N     = 3,
    parameter int SYM_W = 1,
    localparam int RW   = (N > 2) ? $clog2(N) : 1,
    localparam int CW   = $clog2(N*N + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mv_valid,
    output logic                 mv_ready,
    input  logic [RW-1:0]        mv_row,
    input  logic [RW-1:0]        mv_col,
    output logic                 mv_accept,
    output logic                 mv_reject,
    output logic [SYM_W-1:0]     cur_player,
    output logic [N*N-1:0]       cell_valid,
    output logic [N*N*SYM_W-1:0] cell_sym,
    output logic [CW-1:0]        move_count,
    output logic                 game_over,
    output logic                 draw,
    output logic                 winner_valid,
    output logic [SYM_W-1:0]     winner
);

    localparam int IW = $clog2(N*N);

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    state_t                 state_reg, state_next;
    logic [N*N-1:0]         cell_valid_reg, cell_valid_next;
    logic [N*N*SYM_W-1:0]   cell_sym_reg, cell_sym_next;
    logic [CW-1:0]          move_count_reg, move_count_next;
    logic [SYM_W-1:0]       cur_player_reg, cur_player_next;
    logic                   accept_reg, accept_next;
    logic                   reject_reg, reject_next;
    logic                   game_over_reg, game_over_next;
    logic                   draw_reg, draw_next;
    logic                   winner_valid_reg, winner_valid_next;
    logic [SYM_W-1:0]       winner_reg, winner_next;

    logic                   win_found;
    logic [SYM_W-1:0]       win_sym;
    logic [IW-1:0]          cell_idx;
    logic                   in_range;

    assign cell_idx = IW'(mv_row) * IW'(N) + IW'(mv_col);
    assign in_range = (int'(mv_row) < N) && (int'(mv_col) < N);

`ifdef TTT_WIN_DETECT_EN
    localparam int NL = 2*N + 2;

    // Lines 0..N-1 are rows, N..2N-1 columns, 2N the main diagonal, 2N+1 the anti-diagonal.
    // A line hits when every cell is occupied and matches the symbol of the line's first cell.
    logic [NL-1:0]       line_hit;
    logic [NL*SYM_W-1:0] line_sym;
    logic [N-1:0]        diag_ok, anti_ok;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_line
            logic [N-1:0] row_ok, col_ok;
            for (gj = 0; gj < N; gj++) begin : g_cell
                assign row_ok[gj] = cell_valid_reg[gi*N+gj] &&
                    (cell_sym_reg[(gi*N+gj)*SYM_W +: SYM_W] == cell_sym_reg[(gi*N)*SYM_W +: SYM_W]);
                assign col_ok[gj] = cell_valid_reg[gj*N+gi] &&
                    (cell_sym_reg[(gj*N+gi)*SYM_W +: SYM_W] == cell_sym_reg[gi*SYM_W +: SYM_W]);
            end
            assign line_hit[gi]                     = &row_ok;
            assign line_sym[gi*SYM_W +: SYM_W]      = cell_sym_reg[(gi*N)*SYM_W +: SYM_W];
            assign line_hit[N+gi]                   = &col_ok;
            assign line_sym[(N+gi)*SYM_W +: SYM_W]  = cell_sym_reg[gi*SYM_W +: SYM_W];

            assign diag_ok[gi] = cell_valid_reg[gi*N+gi] &&
                (cell_sym_reg[(gi*N+gi)*SYM_W +: SYM_W] == cell_sym_reg[0 +: SYM_W]);
            assign anti_ok[gi] = cell_valid_reg[gi*N+N-1-gi] &&
                (cell_sym_reg[(gi*N+N-1-gi)*SYM_W +: SYM_W] == cell_sym_reg[(N-1)*SYM_W +: SYM_W]);
        end
    endgenerate

    assign line_hit[2*N]                      = &diag_ok;
    assign line_sym[(2*N)*SYM_W +: SYM_W]     = cell_sym_reg[0 +: SYM_W];
    assign line_hit[2*N+1]                    = &anti_ok;
    assign line_sym[(2*N+1)*SYM_W +: SYM_W]   = cell_sym_reg[(N-1)*SYM_W +: SYM_W];

    // Every completed line contains the latest move, so all hits share one symbol.
    always_comb begin
        win_found = |line_hit;
        win_sym   = '0;
        for (int i = NL-1; i >= 0; i--) begin
            if (line_hit[i]) win_sym = line_sym[i*SYM_W +: SYM_W];
        end
    end
`else
    assign win_found = 1'b0;
    assign win_sym   = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= PLAY;
            cell_valid_reg   <= '0;
            cell_sym_reg     <= '0;
            move_count_reg   <= '0;
            cur_player_reg   <= '0;
            accept_reg       <= 1'b0;
            reject_reg       <= 1'b0;
            game_over_reg    <= 1'b0;
            draw_reg         <= 1'b0;
            winner_valid_reg <= 1'b0;
            winner_reg       <= '0;
        end else begin
            state_reg        <= state_next;
            cell_valid_reg   <= cell_valid_next;
            cell_sym_reg     <= cell_sym_next;
            move_count_reg   <= move_count_next;
            cur_player_reg   <= cur_player_next;
            accept_reg       <= accept_next;
            reject_reg       <= reject_next;
            game_over_reg    <= game_over_next;
            draw_reg         <= draw_next;
            winner_valid_reg <= winner_valid_next;
            winner_reg       <= winner_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        cell_valid_next   = cell_valid_reg;
        cell_sym_next     = cell_sym_reg;
        move_count_next   = move_count_reg;
        cur_player_next   = cur_player_reg;
        accept_next       = 1'b0;
        reject_next       = 1'b0;
        game_over_next    = game_over_reg;
        draw_next         = draw_reg;
        winner_valid_next = winner_valid_reg;
        winner_next       = winner_reg;
        case (state_reg)
            PLAY: begin
                if (mv_valid) begin
                    if (!in_range || cell_valid_reg[cell_idx]) begin
                        reject_next = 1'b1;
                    end else begin
                        cell_valid_next[cell_idx]                     = 1'b1;
                        cell_sym_next[int'(cell_idx)*SYM_W +: SYM_W]  = cur_player_reg;
                        move_count_next = move_count_reg + CW'(1);
                        accept_next     = 1'b1;
                        state_next      = CHECK;
                    end
                end
            end
            CHECK: begin
                if (win_found) begin
                    state_next        = OVER;
                    game_over_next    = 1'b1;
                    winner_valid_next = 1'b1;
                    winner_next       = win_sym;
                end else if (move_count_reg == CW'(N*N)) begin
                    state_next     = OVER;
                    game_over_next = 1'b1;
                    draw_next      = 1'b1;
                end else begin
                    cur_player_next = cur_player_reg + SYM_W'(1);
                    state_next      = PLAY;
                end
            end
            OVER: state_next = OVER;
            default: state_next = PLAY;
        endcase
    end

    assign mv_ready     = (state_reg == PLAY);
    assign mv_accept    = accept_reg;
    assign mv_reject    = reject_reg;
    assign cur_player   = cur_player_reg;
    assign cell_valid   = cell_valid_reg;
    assign cell_sym     = cell_sym_reg;
    assign move_count   = move_count_reg;
    assign game_over    = game_over_reg;
    assign draw         = draw_reg;
    assign winner_valid = winner_valid_reg;
    assign winner       = winner_reg;

endmodule
